div_half_precision: RTL and testbench

- Iterative IEEE-754 binary16 (half-precision) floating-point divider for the pipeline arithmetic modules.
- Computes o_Quotient = i_Dividend / i_Divisor with round-to-nearest-even.
- Flags special and out-of-range results on o_Exception.
- Start/done handshake; fixed latency per operation.

---
 rtl/div_half_precision.sv | 171 +++++++++++++++++
 tb/tb_div_half_precision.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_half_precision.sv
// Iterative binary16 divider: restoring mantissa division, one quotient bit per cycle,
// round-to-nearest-even, subnormals flushed, specials decoded at capture.
module div_half_precision (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic        i_Start,
  input  logic [15:0] i_Dividend,
  input  logic [15:0] i_Divisor,
  output logic [15:0] o_Quotient,
  output logic        o_Exception,
  output logic        o_Busy,
  output logic        o_Done
);

  localparam int unsigned EXP_W      = 5;
  localparam int unsigned FRAC_W     = 10;
  localparam int unsigned MANT_W     = 11;
  localparam int unsigned QUO_W      = 14;
  localparam int unsigned REM_W      = 12;
  localparam int unsigned EXPS_W     = 7;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned DIV_CYCLES = 14;

  localparam logic [15:0] QNAN = 16'h7E00;

  typedef enum logic [1:0] {IDLE, DIVIDE, FINAL} state_t;

  state_t                    state;
  logic [CNT_W-1:0]          cnt;
  logic [MANT_W-1:0]         divisor_m;
  logic [REM_W-1:0]          rem;
  logic [QUO_W-1:0]          quo;
  logic signed [EXPS_W-1:0]  exp_base;
  logic                      special;
  logic [15:0]               special_q;
  logic                      special_exc;
  logic                      res_sign;

  // Operand decode and special-case priority, evaluated on the live inputs
  logic [EXP_W-1:0]         ea, eb;
  logic [FRAC_W-1:0]        fa, fb;
  logic                     sgn_c;
  logic                     a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic                     spec_c, spec_exc_c;
  logic [15:0]              spec_q_c;
  logic signed [EXPS_W-1:0] exp_base_c;

  always_comb begin
    ea         = i_Dividend[14:10];
    eb         = i_Divisor[14:10];
    fa         = i_Dividend[9:0];
    fb         = i_Divisor[9:0];
    sgn_c      = i_Dividend[15] ^ i_Divisor[15];
    a_zero     = (ea == '0);
    b_zero     = (eb == '0);
    a_inf      = (ea == '1) && (fa == '0);
    b_inf      = (eb == '1) && (fb == '0);
    a_nan      = (ea == '1) && (fa != '0);
    b_nan      = (eb == '1) && (fb != '0);
    exp_base_c = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 7'sd15;
    spec_c     = 1'b1;
    spec_exc_c = 1'b1;
    spec_q_c   = QNAN;
    if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) begin
      spec_q_c = QNAN;
    end else if (a_inf || b_zero) begin
      spec_q_c = {sgn_c, 5'h1F, 10'h000};
    end else if (b_inf) begin
      spec_q_c = {sgn_c, 15'h0000};
    end else if (a_zero) begin
      spec_q_c   = {sgn_c, 15'h0000};
      spec_exc_c = 1'b0;
    end else begin
      spec_c = 1'b0;
    end
  end

  // One restoring step: subtract the divisor when the partial remainder allows it
  logic              ge;
  logic [MANT_W-1:0] rem_sel;

  always_comb begin
    ge      = (rem >= {1'b0, divisor_m});
    rem_sel = ge ? (rem[MANT_W-1:0] - divisor_m) : rem[MANT_W-1:0];
  end

  // Normalise, round to nearest even, and range-check the finished quotient
  logic [MANT_W-1:0]        mant_raw, mant_f;
  logic [MANT_W:0]          mant_r;
  logic                     guard, sticky, round_up;
  logic signed [EXPS_W-1:0] exp_n, exp_f;
  logic [15:0]              res_q;
  logic                     res_exc;

  always_comb begin
    mant_raw = quo[13] ? quo[13:3] : quo[12:2];
    guard    = quo[13] ? quo[2] : quo[1];
    sticky   = (quo[13] ? (|quo[1:0]) : quo[0]) | (rem != '0);
    exp_n    = quo[13] ? exp_base : (exp_base - 7'sd1);
    round_up = guard & (sticky | mant_raw[0]);
    mant_r   = {1'b0, mant_raw} + (MANT_W+1)'(round_up);
    mant_f   = mant_r[MANT_W] ? mant_r[MANT_W:1] : mant_r[MANT_W-1:0];
    exp_f    = exp_n + (mant_r[MANT_W] ? 7'sd1 : 7'sd0);
    res_q    = {res_sign, exp_f[4:0], mant_f[9:0]};
    res_exc  = 1'b0;
    if (exp_f >= 7'sd31) begin
      res_q   = {res_sign, 5'h1F, 10'h000};
      res_exc = 1'b1;
    end else if (exp_f <= 7'sd0) begin
      res_q   = {res_sign, 15'h0000};
      res_exc = 1'b1;
    end
  end

  // Control FSM and datapath registers
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state       <= IDLE;
      cnt         <= '0;
      divisor_m   <= '0;
      rem         <= '0;
      quo         <= '0;
      exp_base    <= '0;
      special     <= 1'b0;
      special_q   <= '0;
      special_exc <= 1'b0;
      res_sign    <= 1'b0;
      o_Quotient  <= '0;
      o_Exception <= 1'b0;
      o_Busy      <= 1'b0;
      o_Done      <= 1'b0;
    end else begin
      o_Done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_Start) begin
            divisor_m   <= {1'b1, fb};
            rem         <= REM_W'({1'b1, fa});
            quo         <= '0;
            exp_base    <= exp_base_c;
            special     <= spec_c;
            special_q   <= spec_q_c;
            special_exc <= spec_exc_c;
            res_sign    <= sgn_c;
            cnt         <= '0;
            o_Busy      <= 1'b1;
            state       <= DIVIDE;
          end
        end
        DIVIDE: begin
          quo <= {quo[QUO_W-2:0], ge};
          rem <= {rem_sel, 1'b0};
          if (cnt == CNT_W'(DIV_CYCLES - 1)) begin
            state <= FINAL;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        FINAL: begin
          o_Quotient  <= special ? special_q : res_q;
          o_Exception <= special ? special_exc : res_exc;
          o_Done      <= 1'b1;
          o_Busy      <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_half_precision.sv
// Bench for div_half_precision: directed vector table, handshake/reset sequences,
// and random operands against an exact-arithmetic binary16 division model.
module tb_div_half_precision;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] dividend, divisor;
  logic [15:0] quotient;
  logic        exception, busy, done;

  int checks = 0;
  int errors = 0;

  div_half_precision dut (
    .i_Clk       (clk),
    .i_Reset     (rst),
    .i_Start     (start),
    .i_Dividend  (dividend),
    .i_Divisor   (divisor),
    .o_Quotient  (quotient),
    .o_Exception (exception),
    .o_Busy      (busy),
    .o_Done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic        exc;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Exact model: {exc, result} from the binary16 rules using wide integer arithmetic
  function automatic logic [16:0] ref_div(input logic [15:0] a, input logic [15:0] b);
    logic s;
    int ea, eb, e, be;
    longint ma, mb, num, q, r, mant;
    bit g, st, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    s = a[15] ^ b[15];
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    a_nan = (ea == 31) && (a[9:0] != 0);
    b_nan = (eb == 31) && (b[9:0] != 0);
    a_inf = (ea == 31) && (a[9:0] == 0);
    b_inf = (eb == 31) && (b[9:0] == 0);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    if (a_nan || b_nan) return {1'b1, 16'h7E00};
    if ((a_inf && b_inf) || (a_zero && b_zero)) return {1'b1, 16'h7E00};
    if (a_inf || b_zero) return {1'b1, s, 15'h7C00};
    if (b_inf) return {1'b1, s, 15'h0000};
    if (a_zero) return {1'b0, s, 15'h0000};
    ma = 64'd1024 + longint'(a[9:0]);
    mb = 64'd1024 + longint'(b[9:0]);
    num = ma << 40;
    q = num / mb;
    r = num % mb;
    e = ea - eb;
    if (q >= (64'd1 << 40)) begin
      mant = q >> 30;
      g    = q[29];
      st   = ((q & ((64'd1 << 29) - 1)) != 0) || (r != 0);
    end else begin
      mant = q >> 29;
      g    = q[28];
      st   = ((q & ((64'd1 << 28) - 1)) != 0) || (r != 0);
      e    = e - 1;
    end
    if (g && (st || mant[0])) mant = mant + 1;
    if (mant == 2048) begin
      mant = 1024;
      e    = e + 1;
    end
    be = e + 15;
    if (be >= 31) return {1'b1, s, 15'h7C00};
    if (be <= 0) return {1'b1, s, 15'h0000};
    return {1'b0, s, 5'(be), mant[9:0]};
  endfunction

  function automatic real h2r(input logic [15:0] h);
    real v;
    v = (1.0 + real'(h[9:0]) / 1024.0) * $pow(2.0, real'(int'(h[14:10]) - 15));
    return h[15] ? -v : v;
  endfunction

  task automatic wait_done(input int limit, output int k);
    k = -1;
    for (int i = 1; i <= limit; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] q, output logic e, output int lat);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(40, lat);
    q = quotient;
    e = exception;
  endtask

  vec_t vecs[17];
  logic [15:0] rq;
  logic        re;
  int          lat, k, seen;
  logic [16:0] m;
  logic [15:0] ra, rb;
  real         exact, got, err;

  initial begin
    vecs[0]  = '{16'h3C00, 16'h4000, 16'h3800, 1'b0};
    vecs[1]  = '{16'h4200, 16'h4000, 16'h3E00, 1'b0};
    vecs[2]  = '{16'hC000, 16'h4000, 16'hBC00, 1'b0};
    vecs[3]  = '{16'h3C00, 16'h4200, 16'h3555, 1'b0};
    vecs[4]  = '{16'h3C00, 16'h0000, 16'h7C00, 1'b1};
    vecs[5]  = '{16'hBC00, 16'h0000, 16'hFC00, 1'b1};
    vecs[6]  = '{16'h0000, 16'h0000, 16'h7E00, 1'b1};
    vecs[7]  = '{16'h7C00, 16'h7C00, 16'h7E00, 1'b1};
    vecs[8]  = '{16'h7E01, 16'h3C00, 16'h7E00, 1'b1};
    vecs[9]  = '{16'h0000, 16'h3C00, 16'h0000, 1'b0};
    vecs[10] = '{16'h3C00, 16'h7C00, 16'h0000, 1'b1};
    vecs[11] = '{16'h7BFF, 16'h3800, 16'h7C00, 1'b1};
    vecs[12] = '{16'h0400, 16'h7BFF, 16'h0000, 1'b1};
    vecs[13] = '{16'h0001, 16'h3C00, 16'h0000, 1'b0};
    vecs[14] = '{16'hFC00, 16'h3C00, 16'hFC00, 1'b1};
    vecs[15] = '{16'h3C00, 16'hFC00, 16'h8000, 1'b1};
    vecs[16] = '{16'h4000, 16'h3C00, 16'h4000, 1'b0};

    rst = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_quotient", 32'(quotient), 32'h0);
    check("reset_exception", 32'(exception), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      run_op(vecs[i].a, vecs[i].b, rq, re, lat);
      check($sformatf("vec%0d_q %h/%h", i, vecs[i].a, vecs[i].b), 32'(rq), 32'(vecs[i].q));
      check($sformatf("vec%0d_exc", i), 32'(re), 32'(vecs[i].exc));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd15);
    end

    // Reset held two cycles mid-division aborts silently
    @(negedge clk);
    dividend = 16'h3C00;
    divisor = 16'h4200;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("abort_quotient", 32'(quotient), 32'h0);
    check("abort_exception", 32'(exception), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    @(negedge clk) rst = 1'b0;
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done || busy) seen = 1;
    end
    check("abort_no_activity", 32'(seen), 32'h0);
    run_op(16'h4200, 16'h4000, rq, re, lat);
    check("after_abort_q", 32'(rq), 32'h3E00);
    check("after_abort_latency", 32'(lat), 32'd15);

    // Start held high: back-to-back every 16 edges, operands only taken while idle
    @(negedge clk);
    dividend = 16'h4200;
    divisor = 16'h4000;
    start = 1'b1;
    @(posedge clk);
    #1;
    dividend = 16'h3C00;
    divisor = 16'h4200;
    wait_done(40, k);
    check("b2b_first_latency", 32'(k), 32'd15);
    check("b2b_first_q", 32'(quotient), 32'h3E00);
    k = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) begin
        dividend = 16'hC000;
        divisor = 16'h4000;
      end
      if (done) begin
        k = i;
        break;
      end
    end
    start = 1'b0;
    check("b2b_second_spacing", 32'(k), 32'd16);
    check("b2b_second_q", 32'(quotient), 32'h3555);
    repeat (3) @(posedge clk);
    #1;
    check("b2b_idle_after", 32'(busy), 32'h0);

    // A start pulse mid-operation changes nothing
    @(negedge clk);
    dividend = 16'h3C00;
    divisor = 16'h4000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    dividend = 16'h4200;
    divisor = 16'h4000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(40, k);
    check("midpulse_latency", 32'(k + 5), 32'd15);
    check("midpulse_q", 32'(quotient), 32'h3800);
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done || busy) seen = 1;
    end
    check("midpulse_no_second_op", 32'(seen), 32'h0);

    // Random operands against the exact model
    for (int i = 0; i < 300; i++) begin
      if (i % 2 == 0) begin
        ra = {1'($urandom), 5'($urandom_range(1, 30)), 10'($urandom)};
        rb = {1'($urandom), 5'($urandom_range(1, 30)), 10'($urandom)};
      end else begin
        ra = 16'($urandom);
        rb = 16'($urandom);
      end
      m = ref_div(ra, rb);
      run_op(ra, rb, rq, re, lat);
      check($sformatf("rand_q %h/%h", ra, rb), 32'(rq), 32'(m[15:0]));
      check($sformatf("rand_exc %h/%h", ra, rb), 32'(re), 32'(m[16]));
      if (i % 2 == 0 && !m[16]) begin
        exact = h2r(ra) / h2r(rb);
        got = h2r(rq);
        err = (got - exact) / exact;
        if (err < 0.0) err = -err;
        check($sformatf("rand_relerr %h/%h", ra, rb), 32'(err <= $pow(2.0, -11.0)), 32'd1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
